mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a memory access may wait for mem_ready before abort (only with MEM_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 if_req  input  1  fetch requests the instruction word at if_addr.
REQ-005 if_addr  input  32  fetch byte address, word aligned.
REQ-006 if_flush  input  1  fetch redirect; the in-flight fetch result is discarded.
REQ-007 dm_req  input  1  load/store stage requests a data access.
REQ-008 dm_we  input  1  1 = store, 0 = load.
REQ-009 dm_addr  input  32  data byte address.
REQ-010 dm_wdata  input  32  store data.
REQ-011 dm_wstrb  input  4  store byte enables.
REQ-012 mem_rdata  input  32  shared memory read data, valid when mem_ready=1.
REQ-013 mem_ready  input  1  memory completes the current access this cycle.
REQ-014 mem_addr, mem_wdata  output  32 each  registered shared-port address/store data.
REQ-015 mem_valid, mem_we  output  1 each  access in progress / store qualifier.
REQ-016 mem_wstrb  output  4  store byte enables, 0 for reads.
REQ-017 if_data  output  32  fetched instruction; if_valid  output  1  one-cycle strobe.
REQ-018 dm_rdata  output  32  load data; dm_done  output  1  one-cycle completion strobe.
REQ-019 fetch_stop  output  1  drives the fetch stage stop input.
REQ-020 bus_err  output  1  one-cycle abort strobe (0 when MEM_ARB_TIMEOUT_EN undefined).

Function
REQ-021 FSM states IDLE, IF_BUSY, DM_BUSY; one access outstanding at a time.
REQ-022 IDLE: dm_req=1 -> latch dm_* onto mem_*, mem_valid=1, go DM_BUSY; else if_req=1 -> latch if_addr, mem_we=0, mem_wstrb=0, go IF_BUSY.
REQ-023 Simultaneous if_req and dm_req in IDLE: data access wins; fetch waits.
REQ-024 Busy state with mem_ready=1: mem_valid=0 next cycle, return to IDLE, completion strobe that same next cycle with captured mem_rdata.
REQ-025 Minimum latency: request in IDLE at cycle N, mem_ready at N+1, strobe at N+2; back-to-back access may start at N+2.
REQ-026 fetch_stop=1 whenever state is not IF_BUSY completing with mem_ready, or when dm_req is pending in IDLE.
REQ-027 if_flush in IF_BUSY sets a drop flag; completion with drop set produces no if_valid; flag clears on return to IDLE.
REQ-028 if_flush in IDLE or DM_BUSY has no effect.
REQ-029 mem_addr/mem_wdata/mem_we/mem_wstrb hold stable while mem_valid=1.
REQ-030 Requesters hold req and payload until their strobe; the arbiter samples payload only on the IDLE transition.
REQ-031 Store completion asserts dm_done with dm_rdata=mem_rdata don't-care, driven 0.

Reset
REQ-032 reset forces state IDLE, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_done=0, bus_err=0, drop flag=0, timeout counter=0, if_data=0, dm_rdata=0.
REQ-033 reset mid-access abandons the access without any strobe; fetch_stop=1 during reset.

Configuration
REQ-034 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit-or-wider wait counter clears on entry to a busy state, increments each cycle without mem_ready; on reaching TIMEOUT, mem_valid=0, return to IDLE, one-cycle bus_err, no completion strobe.
REQ-035 Macro undefined: no counter logic, bus_err tied 0, busy states wait indefinitely.

Structure
REQ-036 Shared package holds the FSM state typedef (IDLE/IF_BUSY/DM_BUSY) and the NOP encoding constant used by fetch.
REQ-037 Optional sub-module mem_arb_timer holds the timeout counter, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-038 if_req=1, if_addr=0x100, mem_ready one cycle after mem_valid, mem_rdata=0x00500093 -> mem_addr=0x100, if_valid with if_data=0x00500093 two cycles after request.
REQ-039 if_req and dm_req (load, dm_addr=0x2000) same cycle -> load served first, dm_done, then fetch; fetch_stop=1 throughout load.
REQ-040 Store dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_wstrb=0x3 -> mem_we=1, mem_wstrb=0x3 stable until mem_ready, dm_done one cycle later.
REQ-041 if_flush during IF_BUSY, mem_ready two cycles later -> no if_valid; next fetch completes normally.
REQ-042 reset asserted during DM_BUSY -> next cycle mem_valid=0, state IDLE, no dm_done.
REQ-043 MEM_ARB_TIMEOUT_EN defined, TIMEOUT=4, mem_ready held 0 -> bus_err strobe after 4 wait cycles, mem_valid=0, no if_valid/dm_done.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type and fetch NOP encoding for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} arb_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and shared-memory port bundle
// slave  : arbiter side (takes fetch/data requests and memory responses, drives the memory port and strobes)
// master : environment side (fetch stage, load/store stage and memory)
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] if_data;
  logic        if_valid;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        fetch_stop;
  logic        bus_err;
  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_valid, mem_we, mem_wstrb, if_data, if_valid, dm_rdata, dm_done,
           fetch_stop, bus_err
  );
  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_valid, mem_we, mem_wstrb, if_data, if_valid, dm_rdata, dm_done,
           fetch_stop, bus_err
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: busy-wait watchdog, built only when MEM_ARB_TIMEOUT_EN is defined
// clk, reset : clock and synchronous active-high reset
// busy       : arbiter has an access outstanding
// mem_ready  : memory completes the access this cycle
// expire     : TIMEOUT-th consecutive cycle without mem_ready
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ready,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1) < 8 ? 8 : $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // Held at zero while idle so every busy entry starts from a cleared count
  always_ff @(posedge clk)
    cnt <= (reset || !busy || mem_ready || expire) ? '0 : cnt + 1'b1;
  assign expire = busy && !mem_ready && cnt == W'(TIMEOUT - 1);
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory port between fetch and load/store
// clk, reset : clock and synchronous active-high reset
// bus        : mem_arbiter_if.slave (requests in, registered memory port and completion strobes out)
// MEM_ARB_TIMEOUT_EN : when defined, adds parameter TIMEOUT and a watchdog that aborts a stalled
//                      access with a one-cycle bus_err; otherwise bus_err stays 0 and accesses wait forever
module mem_arbiter
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_TIMEOUT_EN
  #(parameter int TIMEOUT = 255)
`endif
(
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  arb_state_e state, state_n;
  logic       busy, drop, expire;
  assign busy = state == IF_BUSY || state == DM_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .mem_ready(bus.mem_ready),
    .expire   (expire)
  );
`else
  assign expire = 1'b0;
`endif
  // Only a fetch that is completing this cycle lets the fetch stage advance
  assign bus.fetch_stop = reset || !(state == IF_BUSY && bus.mem_ready);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // Data access wins over fetch; unknown encodings fall back to IDLE
  always_comb begin
    state_n = IDLE;
    if (state == IDLE)
      state_n = bus.dm_req ? DM_BUSY : bus.if_req ? IF_BUSY : IDLE;
    else if (busy && !bus.mem_ready && !expire)
      state_n = state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wstrb <= '0;
      bus.if_data   <= '0;
      bus.if_valid  <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_done   <= 1'b0;
      bus.bus_err   <= 1'b0;
      drop          <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_done  <= 1'b0;
      bus.bus_err  <= expire;
      if (state == IDLE) begin
        drop <= 1'b0;
        if (bus.dm_req) begin
          bus.mem_addr  <= bus.dm_addr;
          bus.mem_wdata <= bus.dm_wdata;
          bus.mem_we    <= bus.dm_we;
          bus.mem_wstrb <= bus.dm_we ? bus.dm_wstrb : 4'h0;
          bus.mem_valid <= 1'b1;
        end else if (bus.if_req) begin
          bus.mem_addr  <= bus.if_addr;
          bus.mem_we    <= 1'b0;
          bus.mem_wstrb <= 4'h0;
          bus.mem_valid <= 1'b1;
        end
      end else if (busy && (bus.mem_ready || expire)) begin
        bus.mem_valid <= 1'b0;
        bus.mem_we    <= 1'b0;
        bus.mem_wstrb <= 4'h0;
        // A flush arriving on the completing cycle still discards the result
        if (bus.mem_ready && state == IF_BUSY) begin
          bus.if_data  <= (drop || bus.if_flush) ? NOP : bus.mem_rdata;
          bus.if_valid <= !(drop || bus.if_flush);
        end
        if (bus.mem_ready && state == DM_BUSY) begin
          bus.dm_rdata <= bus.mem_we ? 32'h0 : bus.mem_rdata;
          bus.dm_done  <= 1'b1;
        end
      end else if (state == IF_BUSY && bus.if_flush)
        drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
`ifdef MEM_ARB_TIMEOUT_EN
  mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wstrb = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
    step(); step();
    check("rst_valid", 32'(bus.mem_valid), 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 0);
    check("rst_if_valid", 32'(bus.if_valid), 0);
    check("rst_dm_done", 32'(bus.dm_done), 0);
    check("rst_bus_err", 32'(bus.bus_err), 0);
    check("rst_if_data", bus.if_data, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_fetch_stop", 32'(bus.fetch_stop), 1);
    reset = 0;
    // basic fetch with minimum latency
    bus.if_req = 1; bus.if_addr = 32'h100;
    #1 check("f1_stop_idle", 32'(bus.fetch_stop), 1);
    step();
    check("f1_valid", 32'(bus.mem_valid), 1);
    check("f1_addr", bus.mem_addr, 32'h100);
    check("f1_we", 32'(bus.mem_we), 0);
    check("f1_wstrb", 32'(bus.mem_wstrb), 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0050_0093;
    #1 check("f1_stop_done", 32'(bus.fetch_stop), 0);
    step();
    check("f1_if_valid", 32'(bus.if_valid), 1);
    check("f1_if_data", bus.if_data, 32'h0050_0093);
    check("f1_valid_off", 32'(bus.mem_valid), 0);
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    check("f1_strobe_1cyc", 32'(bus.if_valid), 0);
    // simultaneous fetch and load: load first
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'h5555_5555; bus.dm_wstrb = 4'hF;
    #1 check("ld_stop_idle", 32'(bus.fetch_stop), 1);
    step();
    check("ld_addr", bus.mem_addr, 32'h2000);
    check("ld_we", 32'(bus.mem_we), 0);
    check("ld_wstrb", 32'(bus.mem_wstrb), 0);
    check("ld_stop_busy", 32'(bus.fetch_stop), 1);
    step();
    check("ld_wait_valid", 32'(bus.mem_valid), 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_F00D;
    #1 check("ld_stop_ready", 32'(bus.fetch_stop), 1);
    step();
    check("ld_done", 32'(bus.dm_done), 1);
    check("ld_rdata", bus.dm_rdata, 32'hCAFE_F00D);
    check("ld_no_if_valid", 32'(bus.if_valid), 0);
    bus.dm_req = 0; bus.mem_ready = 0;
    step();
    check("ld_fetch_addr", bus.mem_addr, 32'h104);
    check("ld_fetch_valid", 32'(bus.mem_valid), 1);
    check("ld_done_1cyc", 32'(bus.dm_done), 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0000_0013;
    step();
    check("ld_fetch_if_valid", 32'(bus.if_valid), 1);
    check("ld_fetch_if_data", bus.if_data, 32'h0000_0013);
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    // store
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_wstrb = 4'h3;
    step();
    check("st_addr", bus.mem_addr, 32'h2004);
    check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("st_we", 32'(bus.mem_we), 1);
    check("st_wstrb", 32'(bus.mem_wstrb), 32'h3);
    step();
    check("st_we_hold", 32'(bus.mem_we), 1);
    check("st_wstrb_hold", 32'(bus.mem_wstrb), 32'h3);
    check("st_dm_done_early", 32'(bus.dm_done), 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h1234_5678;
    step();
    check("st_done", 32'(bus.dm_done), 1);
    check("st_rdata_zero", bus.dm_rdata, 0);
    check("st_valid_off", 32'(bus.mem_valid), 0);
    check("st_wstrb_off", 32'(bus.mem_wstrb), 0);
    bus.dm_req = 0; bus.dm_we = 0; bus.mem_ready = 0;
    step();
    // flush during fetch, then a normal fetch with flush held in IDLE
    bus.if_req = 1; bus.if_addr = 32'h200;
    step();
    bus.if_flush = 1;
    step();
    bus.if_flush = 0;
    step();
    bus.mem_ready = 1; bus.mem_rdata = 32'h0000_0BAD;
    step();
    check("fl_no_if_valid", 32'(bus.if_valid), 0);
    check("fl_valid_off", 32'(bus.mem_valid), 0);
    bus.if_addr = 32'h300; bus.mem_ready = 0; bus.if_flush = 1;
    step();
    bus.if_flush = 0;
    check("fl_next_addr", bus.mem_addr, 32'h300);
    check("fl_next_valid", 32'(bus.mem_valid), 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'h00A0_0113;
    step();
    check("fl_next_if_valid", 32'(bus.if_valid), 1);
    check("fl_next_if_data", bus.if_data, 32'h00A0_0113);
    bus.if_req = 0; bus.mem_ready = 0;
    step();
    // reset during a data access
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h3000;
    step();
    check("rs_valid", 32'(bus.mem_valid), 1);
    reset = 1;
    #1 check("rs_fetch_stop", 32'(bus.fetch_stop), 1);
    step();
    check("rs_valid_off", 32'(bus.mem_valid), 0);
    check("rs_no_done", 32'(bus.dm_done), 0);
    reset = 0; bus.dm_req = 0; bus.mem_ready = 1; bus.mem_rdata = 32'h7777_7777;
    step();
    check("rs_idle_no_done", 32'(bus.dm_done), 0);
    check("rs_idle_no_valid", 32'(bus.mem_valid), 0);
    bus.mem_ready = 0;
    // stalled fetch
    bus.if_req = 1; bus.if_addr = 32'h400;
    step();
    check("to_valid", 32'(bus.mem_valid), 1);
    step(); step(); step();
    check("to_wait_valid", 32'(bus.mem_valid), 1);
    check("to_wait_err", 32'(bus.bus_err), 0);
`ifdef MEM_ARB_TIMEOUT_EN
    step();
    check("to_bus_err", 32'(bus.bus_err), 1);
    check("to_valid_off", 32'(bus.mem_valid), 0);
    check("to_no_if_valid", 32'(bus.if_valid), 0);
    bus.if_req = 0;
    step();
    check("to_err_1cyc", 32'(bus.bus_err), 0);
`else
    for (int i = 0; i < 10; i++) step();
    check("nt_still_valid", 32'(bus.mem_valid), 1);
    check("nt_no_err", 32'(bus.bus_err), 0);
    check("nt_no_if_valid", 32'(bus.if_valid), 0);
    bus.mem_ready = 1; bus.mem_rdata = 32'h0040_0193;
    step();
    check("nt_if_valid", 32'(bus.if_valid), 1);
    check("nt_if_data", bus.if_data, 32'h0040_0193);
    bus.if_req = 0; bus.mem_ready = 0;
    step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
